// File: rtl/reg_pipe_hs.sv
// reg_pipe_hs: DEPTH-stage valid/ready register pipeline with bubble collapsing.
// Optional synchronous flush port, enabled by defining REG_PIPE_FLUSH_EN.
module reg_pipe_hs #(
    parameter int              WIDTH     = 8,
    parameter int              DEPTH     = 2,
    parameter logic [WIDTH-1:0] RST_VALUE = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [WIDTH-1:0]             out_data_n,
    output logic [$clog2(DEPTH+1)-1:0]   occ
`ifdef REG_PIPE_FLUSH_EN
    ,
    input  logic                         flush
`endif
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    if (DEPTH < 1) begin : g_bad_depth
        $error("reg_pipe_hs: DEPTH must be >= 1");
    end

    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_d;
    logic [DEPTH-1:0] rdy;
    logic [WIDTH-1:0] d_q [DEPTH];
    logic [WIDTH-1:0] d_d [DEPTH];
    logic [DEPTH:0]   v_up;
    logic [WIDTH-1:0] d_up [DEPTH+1];
    logic             chain;
    logic             flush_w;
    logic [OCC_W-1:0] occ_c;

`ifdef REG_PIPE_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    // A stage can load if it is empty or anything downstream can move.
    always_comb begin : ready_chain
        rdy   = '0;
        chain = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            chain  = !v_q[i] || chain;
            rdy[i] = chain;
        end
    end

    always_comb begin : next_state
        v_up    = {v_q, in_valid};
        d_up[0] = in_data;
        for (int i = 0; i < DEPTH; i++) begin
            d_up[i+1] = d_q[i];
        end
        v_d = v_q;
        d_d = d_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (rdy[i]) begin
                v_d[i] = v_up[i];
                // Bubbles keep the old data word.
                if (v_up[i]) begin
                    d_d[i] = d_up[i];
                end
            end
        end
        if (flush_w) begin
            v_d = '0;
            d_d = d_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                d_q[i] <= RST_VALUE;
            end
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    always_comb begin : popcount
        occ_c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_c = occ_c + OCC_W'(v_q[i]);
        end
    end

    assign in_ready   = rdy[0] && !flush_w;
    assign out_valid  = v_q[DEPTH-1];
    assign out_data   = d_q[DEPTH-1];
    assign out_data_n = ~d_q[DEPTH-1];
    assign occ        = occ_c;

endmodule

// File: tb/tb_reg_pipe_hs.sv
// tb_reg_pipe_hs: scoreboard bench for reg_pipe_hs (WIDTH=8, DEPTH=3, RST_VALUE=A5).
// Flush scenario is exercised only when REG_PIPE_FLUSH_EN is defined.
module tb_reg_pipe_hs;

    localparam int W = 8;
    localparam int D = 3;
    localparam logic [7:0] RV = 8'hA5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic [7:0] out_data_n;
    logic [1:0] occ;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_n, pop_n, first_acc, first_pop, last_pop;
    logic [7:0] exp_q [$];

    reg_pipe_hs #(
        .WIDTH(W),
        .DEPTH(D),
        .RST_VALUE(RV)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_data_n(out_data_n),
        .occ(occ)
`ifdef REG_PIPE_FLUSH_EN
        ,
        .flush(flush)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Stimulus side: record every accepted word as the next expected output.
    always begin
        @(negedge clk);
        #4;
        if (!rst && in_valid && in_ready) begin
            exp_q.push_back(in_data);
            acc_n++;
            if (acc_n == 1) first_acc = cyc;
        end
    end

    // Monitor: compare each word the DUT hands downstream.
    always begin
        @(negedge clk);
        #4;
        if (rst || flush) begin
            exp_q.delete();
        end else if (out_valid && out_ready) begin
            pop_n++;
            if (pop_n == 1) first_pop = cyc;
            last_pop = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_word: got %0h expected none", out_data);
            end else begin
                chk("out_word", out_data, exp_q.pop_front());
            end
        end
    end

    task automatic drive(input logic v, input logic [7:0] d);
        @(negedge clk);
        in_valid = v;
        in_data  = d;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 8'hEE);
    endtask

    task automatic clr();
        acc_n     = 0;
        pop_n     = 0;
        first_acc = -1;
        first_pop = -1;
        last_pop  = -1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        clr();
        // T1 reset
        repeat (2) @(negedge clk);
        #1;
        chk("t1_out_valid", out_valid, 1'b0);
        chk("t1_out_data", out_data, 8'hA5);
        chk("t1_out_data_n", out_data_n, 8'h5A);
        chk("t1_occ", occ, 2'd0);
        chk("t1_in_ready", in_ready, 1'b1);
        rst = 1'b0;

        // T2 streaming
        out_ready = 1'b1;
        clr();
        for (int k = 1; k <= 16; k++) drive(1'b1, 8'(k));
        idle(6);
        #1;
        chk("t2_pops", pop_n, 16);
        chk("t2_latency", first_pop - first_acc, 3);
        chk("t2_no_gaps", last_pop - first_pop, 15);
        chk("t2_sb_empty", exp_q.size(), 0);

        // T3 backpressure
        out_ready = 1'b0;
        clr();
        drive(1'b1, 8'h11);
        drive(1'b1, 8'h22);
        drive(1'b1, 8'h33);
        drive(1'b1, 8'h44);
        #1;
        chk("t3_full_ready", in_ready, 1'b0);
        chk("t3_full_occ", occ, 2'd3);
        chk("t3_full_valid", out_valid, 1'b1);
        chk("t3_full_data", out_data, 8'h11);
        repeat (3) drive(1'b1, 8'h44);
        #1;
        chk("t3_stable_data", out_data, 8'h11);
        chk("t3_stable_occ", occ, 2'd3);
        drive(1'b1, 8'h44);
        out_ready = 1'b1;
        #1;
        chk("t3_pushpop_ready", in_ready, 1'b1);
        idle(1);
        #1;
        chk("t3_pushpop_occ", occ, 2'd3);
        chk("t3_next_data", out_data, 8'h22);
        idle(5);
        #1;
        chk("t3_pops", pop_n, 4);
        chk("t3_sb_empty", exp_q.size(), 0);

        // T4 bubble collapsing
        out_ready = 1'b0;
        clr();
        drive(1'b1, 8'h55);
        idle(2);
        drive(1'b1, 8'h66);
        idle(2);
        #1;
        chk("t4_occ", occ, 2'd2);
        chk("t4_in_ready", in_ready, 1'b1);
        chk("t4_out_data", out_data, 8'h55);
        out_ready = 1'b1;
        idle(4);
        #1;
        chk("t4_pops", pop_n, 2);
        chk("t4_empty_valid", out_valid, 1'b0);
        chk("t4_empty_hold", out_data, 8'h66);
        chk("t4_empty_ready", in_ready, 1'b1);

        // T5 reset mid-stream
        out_ready = 1'b0;
        clr();
        drive(1'b1, 8'hA1);
        drive(1'b1, 8'hA2);
        drive(1'b1, 8'hA3);
        idle(1);
        #1;
        chk("t5_occ_full", occ, 2'd3);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        #1;
        chk("t5_occ", occ, 2'd0);
        chk("t5_out_valid", out_valid, 1'b0);
        chk("t5_out_data", out_data, 8'hA5);
        out_ready = 1'b1;
        clr();
        drive(1'b1, 8'h77);
        idle(5);
        #1;
        chk("t5_pops", pop_n, 1);
        chk("t5_latency", first_pop - first_acc, 3);

`ifdef REG_PIPE_FLUSH_EN
        // T6 flush
        out_ready = 1'b0;
        clr();
        drive(1'b1, 8'hB1);
        drive(1'b1, 8'hB2);
        drive(1'b1, 8'hB3);
        idle(1);
        #1;
        chk("t6_occ_full", occ, 2'd3);
        drive(1'b1, 8'h99);
        flush = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("t6_flush_ready", in_ready, 1'b0);
        idle(1);
        flush = 1'b0;
        #1;
        chk("t6_occ", occ, 2'd0);
        chk("t6_out_valid", out_valid, 1'b0);
        idle(4);
        #1;
        chk("t6_no_output", pop_n, 0);
        chk("t6_data_held", out_data, 8'hB1);
`endif

        chk("sb_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
